gcd_issue_ctrl: RTL and testbench
=================================

Name: gcd_issue_ctrl

Overview:
- Upstream sequencer for the GCD datapath core.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Launches one core computation at a time (go / x_out / y_out), waits for the core's done, and captures the core's result into a valid/ready result register.
- Handles zero operands without using the core; aborts hung computations with a timeout.

Parameters:
- WIDTH, 5: operand and result width; matches the core's width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- TIMEOUT, 64: maximum cycles waited for done after go before aborting; at least 2.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  FIFO can accept a pair; equal to !full.
- in_x  in  WIDTH  operand X.
- in_y  in  WIDTH  operand Y.
- go  out  1  start pulse to the core.
- x_out  out  WIDTH  operand X to the core.
- y_out  out  WIDTH  operand Y to the core.
- done  in  1  core completion flag.
- gcd_a  in  WIDTH  core result; valid in the cycle done=1.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer accepts the result.
- res_gcd  out  WIDTH  result value.
- res_err  out  1  result is invalid: 0,0 input or timeout.
- busy  out  1  state is not IDLE, or the FIFO is non-empty.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: FIFO empty (in_ready=1), state=IDLE, go=0, x_out=0, y_out=0, res_valid=0, res_gcd=0, res_err=0, timeout counter=0.
- Reset mid-operation: all of the above applies immediately and all queued pairs are discarded. A late done from the core after reset is ignored because the state is IDLE.
- FIFO push: occurs when in_valid && in_ready.
- FIFO full: in_ready=0. A push is refused even if a pop happens in the same cycle.
- Pointer wrap: pointers wrap modulo DEPTH. An extra occupancy bit distinguishes full from empty.
- State encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, HOLD=2'b11.
- IDLE:
  - Waits for FIFO non-empty. The earliest pop is the cycle after the push edge.
  - On pop, the head pair is registered into x_out/y_out.
  - If both operands are nonzero: go to ISSUE.
  - If x==0 or y==0: no go pulse. Load res_gcd = x|y and res_err = (x==0 && y==0), set res_valid, go to HOLD.
- ISSUE:
  - go=1 for exactly one cycle; the timeout counter is cleared.
  - Next state is WAIT unconditionally. done is ignored in this cycle.
- WAIT:
  - The counter increments each cycle.
  - On done=1: res_gcd <= gcd_a, res_err <= 0, res_valid <= 1, go to HOLD.
  - If the counter reaches TIMEOUT-1 without done: res_gcd <= 0, res_err <= 1, res_valid <= 1, go to HOLD.
  - If done and the timeout occur in the same cycle, done wins.
- HOLD:
  - res_valid stays at 1, and res_gcd/res_err stay stable until res_ready=1.
  - On handshake: res_valid <= 0 and state goes to IDLE.
  - The next pop happens no earlier than the following cycle, so there is at most one computation in flight.
- x_out/y_out hold their value from the pop through HOLD; they change only on a pop.
- Latency, nonzero pair into an empty idle block, no backpressure:
  - push edge, then pop at +1, ISSUE at +2, WAIT from +3.
  - res_valid rises one cycle after done is sampled.
- Zero-operand pair: res_valid rises 2 cycles after the push edge.
- The result order equals the input order.

Decomposition:
- Shared package gcd_pkg holds:
  - the state encodings above,
  - the default WIDTH (5),
  - the ERR flag meaning,
  - the default TIMEOUT, also reused by the core's bench.
- One sub-module: gcd_op_fifo.
  - Synchronous FIFO of {x,y} pairs, 2*WIDTH bits wide, depth DEPTH.
  - Ports: clock, reset_n, push, pop, wdata, rdata, full, empty.
  - Show-ahead: rdata is the head entry.
- gcd_issue_ctrl contains the FSM, timeout counter and result register.

Test Plan:
- Push (12,18); core model returns done with gcd_a=6 after 5 cycles; res_ready=1 -> one go pulse at push+2, res_gcd=6, res_err=0, res_valid for 1 cycle.
- Push (0,7) and then (0,0) -> go never asserts; results in order: (7, err=0), then (0, err=1).
- Hold res_ready=0 and push 4 pairs (9,6),(10,4),(21,14),(8,12) with the model returning 3,2,7,4 -> in_ready=0 after the 4th push and a 5th in_valid is held off. Release res_ready -> results 3,2,7,4 in order, only one go per result, and in_ready returns to 1.
- Core model never asserts done, TIMEOUT=64 -> res_valid rises with res_gcd=0, res_err=1; the next queued pair then issues normally.
- done in the same cycle as the timeout expiry -> gcd_a is taken and res_err=0.
- Assert reset_n=0 in WAIT with 2 pairs queued; a late done arrives after release -> all outputs are at reset values, no res_valid, no go.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD issue controller and its core: state
// encodings, default operand width and timeout, and the result error flag.
package gcd_pkg;

  // Operand/result width shared with the GCD datapath core.
  localparam int GCD_WIDTH = 5;

  // Cycles allowed between go and done before a computation is abandoned.
  localparam int GCD_TIMEOUT = 64;

  // res_err meaning: 0 = res_gcd is a valid result, 1 = no valid result
  // (both operands were zero, or the core never reported done).
  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_INVALID = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } issue_state_e;

endpackage

// File: rtl/gcd_op_fifo.sv
// Show-ahead synchronous FIFO holding {x,y} operand pairs.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The empty flag is registered: a pop is reflected in the same cycle, a push
// becomes visible one cycle after the write, so the consumer always decodes
// from a flop and the head word has settled before it is captured.
module gcd_op_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   rd_ptr_nxt;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = do_pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign rdata      = mem[rd_ptr[AW-1:0]];

  // Pointer and empty-flag registers; the flag compares against the
  // pre-push write pointer so new entries appear a cycle after the write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr <= rd_ptr_nxt;
      empty  <= (rd_ptr_nxt == wr_ptr);
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/gcd_issue_ctrl.sv
// Upstream sequencer for the GCD core: queues operand pairs, launches one
// computation at a time, short-circuits zero operands, aborts hung
// computations after TIMEOUT cycles and presents results in input order.
//
// Handshakes: both streams use valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both 1; a producer holds valid and
// its data stable until that edge, and ready never depends on valid.
module gcd_issue_ctrl
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             go,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  input  logic             done,
  input  logic [WIDTH-1:0] gcd_a,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_gcd,
  output logic             res_err,
  output logic             busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  issue_state_e state;
  issue_state_e state_nxt;

  logic [CW-1:0]        cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [2*WIDTH-1:0]   fifo_rdata;
  logic [WIDTH-1:0]     head_x;
  logic [WIDTH-1:0]     head_y;
  logic                 head_zero;
  logic                 timed_out;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign head_x    = fifo_rdata[2*WIDTH-1:WIDTH];
  assign head_y    = fifo_rdata[WIDTH-1:0];
  assign head_zero = (head_x == '0) || (head_y == '0);
  // done takes priority: the timeout only fires in a WAIT cycle without done.
  assign timed_out = (state == ST_WAIT) && !done && (cnt == CNT_LAST);
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  gcd_op_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   ({in_x, in_y}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, FIFO pop and the one-cycle go pulse.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    go        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = head_zero ? ST_HOLD : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        go        = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (done || timed_out) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand registers: loaded only on a pop, held through the whole transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_out <= '0;
      y_out <= '0;
    end else if (fifo_pop) begin
      x_out <= head_x;
      y_out <= head_y;
    end
  end

  // Timeout counter: cleared while go is issued, counts every WAIT cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == ST_ISSUE) begin
      cnt <= '0;
    end else if (state == ST_WAIT) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Result register: loaded from zero operands, the core, or a timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_gcd   <= '0;
      res_err   <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop && head_zero) begin
            res_gcd   <= head_x | head_y;
            res_err   <= ((head_x == '0) && (head_y == '0)) ? ERR_INVALID : ERR_NONE;
            res_valid <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (done) begin
            res_gcd   <= gcd_a;
            res_err   <= ERR_NONE;
            res_valid <= 1'b1;
          end else if (timed_out) begin
            res_gcd   <= '0;
            res_err   <= ERR_INVALID;
            res_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_issue_ctrl.sv
// Self-checking bench for gcd_issue_ctrl: directed latency/boundary steps,
// a randomized phase, a behavioural core model and an in-order scoreboard.
module tb_gcd_issue_ctrl;

  localparam int W  = 5;
  localparam int D  = 4;
  localparam int TO = 64;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         go;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic         done;
  logic [W-1:0] gcd_a;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_gcd;
  logic         res_err;
  logic         busy;

  int total = 0;
  int bad = 0;
  int go_count = 0;
  logic rand_ready = 1'b0;

  // Scoreboard: expected {err, gcd} per accepted pair, in input order.
  logic [W:0] exp_q[$];
  // Core response delay per nonzero pair (0 = never answers).
  int delay_q[$];

  gcd_issue_ctrl #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .go        (go),
    .x_out     (x_out),
    .y_out     (y_out),
    .done      (done),
    .gcd_a     (gcd_a),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_gcd   (res_gcd),
    .res_err   (res_err),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Expected {err, gcd}: zero operands bypass the core; a core that never
  // answers within TO cycles yields an error.
  function automatic logic [W:0] model(input int x, input int y, input int d);
    logic [W:0] r;
    if (x == 0 || y == 0) begin
      r = {((x == 0) && (y == 0)) ? 1'b1 : 1'b0, W'(x | y)};
    end else if (d == 0 || d > TO) begin
      r = {1'b1, W'(0)};
    end else begin
      r = {1'b0, W'(gcd_ref(x, y))};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_ready) res_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one pair; returns #1 after the accepting edge.
  task automatic push_pair(input int x, input int y, input int d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_x = W'(x);
    in_y = W'(y);
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        exp_q.push_back(model(x, y, d));
        if (x != 0 && y != 0) delay_q.push_back(d);
      end
      tick();
    end
    in_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && busy === 1'b0) ok = 1'b1;
      else tick();
    end
    check("drain", 32'(ok), 32'd1);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_go"}, 32'(go), 32'd0);
    check({tag, "_x_out"}, 32'(x_out), 32'd0);
    check({tag, "_y_out"}, 32'(y_out), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_gcd"}, 32'(res_gcd), 32'd0);
    check({tag, "_res_err"}, 32'(res_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- core model ----------------
  // Answers each go after the delay queued for that pair; gcd_a carries junk
  // whenever done is low. Not reset, so a late done can follow a reset.
  logic [W-1:0] core_x = '0;
  logic [W-1:0] core_y = '0;
  bit core_active = 1'b0;
  int core_left = 0;

  initial begin
    done = 1'b0;
    gcd_a = '0;
  end

  always @(negedge clock) begin
    done = 1'b0;
    gcd_a = W'($urandom);
    if (core_active) begin
      if (core_left <= 1) begin
        done = 1'b1;
        gcd_a = W'(gcd_ref(int'(core_x), int'(core_y)));
        core_active = 1'b0;
      end else begin
        core_left--;
      end
    end
    if (go === 1'b1) begin
      go_count++;
      core_x = x_out;
      core_y = y_out;
      core_left = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
      core_active = (core_left != 0);
    end
  end

  // ---------------- scoreboard / result monitor ----------------
  bit prev_hold = 1'b0;
  logic [W-1:0] prev_gcd = '0;
  logic prev_err = 1'b0;

  always @(negedge clock) begin
    logic [W:0] e;
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_gcd", 32'(res_gcd), 32'(prev_gcd));
        check("hold_err", 32'(res_err), 32'(prev_err));
      end
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("res_gcd", 32'(res_gcd), 32'(e[W-1:0]));
        check("res_err", 32'(res_err), 32'(e[W]));
      end
      prev_hold = (res_valid === 1'b1) && (res_ready !== 1'b1);
      prev_gcd = res_gcd;
      prev_err = res_err;
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int g0;
    int nz;
    int rise;
    int rv;
    bit seen;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    res_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // (12,18): go at push+2, done after 5 WAIT cycles, res_valid for one cycle.
    res_ready = 1'b1;
    g0 = go_count;
    push_pair(12, 18, 5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("lat_go", 32'(go), 32'(c == 2));
      check("lat_res_valid", 32'(res_valid), 32'(c == 3 + 5));
      if (c == 2) begin
        check("lat_x_out", 32'(x_out), 32'd12);
        check("lat_y_out", 32'(y_out), 32'd18);
      end
      if (c == 8) check("lat_res_gcd", 32'(res_gcd), 32'd6);
      tick();
    end
    check("single_go", 32'(go_count - g0), 32'd1);

    // Zero operands: no go, res_valid 2 cycles after push.
    g0 = go_count;
    push_pair(0, 7, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("zero_res_valid", 32'(res_valid), 32'(c == 2));
      tick();
    end
    push_pair(0, 0, 0);
    wait_drain();
    check("zero_no_go", 32'(go_count - g0), 32'd0);

    // Backpressure: a held result blocks the FSM, four pairs fill the FIFO.
    res_ready = 1'b0;
    g0 = go_count;
    push_pair(0, 5, 0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (res_valid === 1'b1) seen = 1'b1;
      tick();
    end
    check("blocker_valid", 32'(seen), 32'd1);
    push_pair(9, 6, 3);
    push_pair(10, 4, 4);
    push_pair(21, 14, 2);
    push_pair(8, 12, 6);
    in_valid = 1'b1;
    in_x = W'(15);
    in_y = W'(25);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("full_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    push_pair(15, 25, 3);
    wait_drain();
    check("bp_go_count", 32'(go_count - g0), 32'd5);
    @(negedge clock);
    check("bp_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Hung core: timeout result, then the queued pair issues normally.
    push_pair(12, 18, 0);
    push_pair(9, 6, 3);
    rise = -1;
    for (int c = 1; c < 120 && rise < 0; c++) begin
      @(negedge clock);
      if (res_valid === 1'b1) rise = c;
      tick();
    end
    check("timeout_rise", 32'(rise), 32'(3 + TO));
    wait_drain();

    // done in the expiry cycle wins; one cycle later loses to the timeout.
    push_pair(20, 30, TO);
    push_pair(20, 30, TO + 1);
    wait_drain();

    // Randomized phase with random consumer backpressure.
    rand_ready = 1'b1;
    g0 = go_count;
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      int x;
      int y;
      x = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      if (x != 0 && y != 0) nz++;
      push_pair(x, y, int'($urandom_range(1, 12)));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain();
    rand_ready = 1'b0;
    res_ready = 1'b1;
    check("rand_go_count", 32'(go_count - g0), 32'(nz));

    // Reset in WAIT with two pairs queued; the late done must be ignored.
    g0 = go_count;
    push_pair(12, 18, 30);
    push_pair(9, 6, 3);
    push_pair(21, 14, 3);
    repeat (3) tick();
    @(negedge clock);
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_go", 32'(go_count - g0), 32'd1);
    tick();
    reset_n = 1'b0;
    exp_q.delete();
    delay_q.delete();
    @(negedge clock);
    check_reset_values("midreset");
    tick();
    reset_n = 1'b1;
    g0 = go_count;
    rv = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (res_valid !== 1'b0) rv++;
      tick();
    end
    check("post_reset_res_valid", 32'(rv), 32'd0);
    check("post_reset_go", 32'(go_count - g0), 32'd0);
    @(negedge clock);
    check_reset_values("post_reset");
    tick();

    // Normal operation after reset.
    push_pair(12, 18, 2);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
